// File: rtl/gf_inv_sbox.sv
// rtl/gf_inv_sbox.sv - multi-cycle GF(2^M) inverter (Fermat, A^(2^M-2)), fixed latency M+1
// Optional AES affine pre/post stage (M=8 only) selected per request by mode: SBOX_AFFINE_EN
module gf_inv_sbox #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h11B
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         mode,
    input  logic [M-1:0] data_in,
    output logic [M-1:0] data_out,
    output logic         done,
    output logic         busy
);

    localparam int           CW       = $clog2(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 2);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        FIN  = 3'b100
    } state_t;

    state_t        state;
    logic [M-1:0]  s;
    logic [M-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [M-1:0]  sq;
    logic [M-1:0]  acc_next;
    logic [M-1:0]  pre_val;
    logic [M-1:0]  post_val;

    // Shift-and-add multiply with the reduction folded into each shift of a.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i])
                p = p ^ x;
            x = x[M-1] ? ((x << 1) ^ POLY[M-1:0]) : (x << 1);
        end
        return p;
    endfunction

    assign sq       = gf_mul(s, s);
    assign acc_next = gf_mul(acc, sq);

`ifdef SBOX_AFFINE_EN
    if (M != 8) begin : g_width_check
        $error("gf_inv_sbox: SBOX_AFFINE_EN requires M == 8");
    end

    localparam logic [7:0] AFF_C = 8'h63;
    localparam logic [7:0] AFF_D = 8'h05;

    logic mode_q;

    function automatic logic [M-1:0] affine_fwd(input logic [M-1:0] a);
        logic [7:0] a8;
        logic [7:0] b8;
        a8 = 8'(a);
        for (int i = 0; i < 8; i++)
            b8[i] = a8[i] ^ a8[(i+4)%8] ^ a8[(i+5)%8] ^ a8[(i+6)%8] ^ a8[(i+7)%8] ^ AFF_C[i];
        return M'(b8);
    endfunction

    function automatic logic [M-1:0] affine_inv(input logic [M-1:0] b);
        logic [7:0] b8;
        logic [7:0] a8;
        b8 = 8'(b);
        for (int i = 0; i < 8; i++)
            a8[i] = b8[(i+2)%8] ^ b8[(i+5)%8] ^ b8[(i+7)%8] ^ AFF_D[i];
        return M'(a8);
    endfunction

    // Direction comes from the live input at accept, and from the latched copy at FIN.
    assign pre_val  = mode   ? affine_inv(data_in) : data_in;
    assign post_val = mode_q ? acc : affine_fwd(acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mode_q <= 1'b0;
        else if (state == IDLE && enable)
            mode_q <= mode;
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign pre_val     = data_in;
    assign post_val    = acc;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s        <= '0;
            acc      <= '0;
            cnt      <= '0;
            data_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        s     <= pre_val;
                        acc   <= M'(1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    s   <= sq;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST)
                        state <= FIN;
                end
                FIN: begin
                    data_out <= post_val;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_inv_sbox.sv
// tb/tb_gf_inv_sbox.sv - randomized self-checking bench for gf_inv_sbox against a polynomial-arithmetic model
module tb_gf_inv_sbox;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en8 = 1'b0;
    logic       md8 = 1'b0;
    logic [7:0] din8 = 8'h00;
    logic [7:0] dout8;
    logic       done8;
    logic       busy8;

    int n_tests = 0;
    int n_fail  = 0;
    int fwd_tab [256];

    always #5 clk = ~clk;

    gf_inv_sbox #(.M(8), .POLY(9'h11B)) u8 (
        .clk(clk), .reset_n(reset_n), .enable(en8), .mode(md8),
        .data_in(din8), .data_out(dout8), .done(done8), .busy(busy8)
    );

`ifndef SBOX_AFFINE_EN
    logic       en4 = 1'b0;
    logic       md4 = 1'b0;
    logic [3:0] din4 = 4'h0;
    logic [3:0] dout4;
    logic       done4;
    logic       busy4;

    gf_inv_sbox #(.M(4), .POLY(5'h13)) u4 (
        .clk(clk), .reset_n(reset_n), .enable(en4), .mode(md4),
        .data_in(din4), .data_out(dout4), .done(done4), .busy(busy4)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Carry-less product followed by polynomial long division.
    function automatic int gmul(int a, int b, int m, int poly);
        int p = 0;
        for (int i = 0; i < m; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 2*m-2; i >= m; i--)
            if (((p >> i) & 1) != 0) p = p ^ (poly << (i - m));
        return p;
    endfunction

    function automatic int ginv(int a, int m, int poly);
        if (a == 0) return 0;
        for (int b = 1; b < (1 << m); b++)
            if (gmul(a, b, m, poly) == 1) return b;
        return -1;
    endfunction

    function automatic int rotl8(int x, int n);
        return ((x << n) | (x >> (8 - n))) & 255;
    endfunction

    function automatic int ref8(int d, int md);
`ifdef SBOX_AFFINE_EN
        if (md == 0) return fwd_tab[d];
        for (int x = 0; x < 256; x++)
            if (fwd_tab[x] == d) return x;
        return -1;
`else
        return fwd_tab[d];
`endif
    endfunction

    task automatic run8(input int d, input int md, output int res, output int lat);
        @(negedge clk);
        en8 = 1'b1; din8 = d[7:0]; md8 = md[0];
        @(posedge clk); #1;
        en8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = int'(dout8);
    endtask

`ifndef SBOX_AFFINE_EN
    task automatic run4(input int d, output int res, output int lat);
        @(negedge clk);
        en4 = 1'b1; din4 = d[3:0];
        @(posedge clk); #1;
        en4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = int'(dout4);
    endtask
`endif

    initial begin
        int res, lat, d, md, pulses;
        int exp_q [$];

        for (int x = 0; x < 256; x++) begin
            fwd_tab[x] = ginv(x, 8, 'h11B);
`ifdef SBOX_AFFINE_EN
            fwd_tab[x] = fwd_tab[x] ^ rotl8(fwd_tab[x], 1) ^ rotl8(fwd_tab[x], 2)
                         ^ rotl8(fwd_tab[x], 3) ^ rotl8(fwd_tab[x], 4) ^ 'h63;
`endif
        end

        @(negedge clk);
        check("reset_data_out", dout8, 0);
        check("reset_done", done8, 0);
        check("reset_busy", busy8, 0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SBOX_AFFINE_EN
        run8('h00, 0, res, lat); check("fwd_00", res, 'h63); check("lat_fwd", lat, 8);
        run8('h01, 0, res, lat); check("fwd_01", res, 'h7C);
        run8('h53, 0, res, lat); check("fwd_53", res, 'hED);
        run8('h63, 1, res, lat); check("inv_63", res, 'h00); check("lat_inv", lat, 8);
        run8('hED, 1, res, lat); check("inv_ED", res, 'h53);
        for (int v = 0; v < 256; v++) begin
            run8(v, 0, res, lat);
            check("sweep_fwd", res, fwd_tab[v]);
            run8(res, 1, res, lat);
            check("sweep_roundtrip", res, v);
        end
`else
        run8('h53, 0, res, lat); check("inv_53", res, 'hCA); check("lat_53", lat, 8);
        run8('h01, 0, res, lat); check("inv_01", res, 'h01);
        run8('h00, 0, res, lat); check("inv_00", res, 'h00);

        run4('h2, res, lat); check("m4_inv_2", res, 'h9); check("m4_lat", lat, 4);
        for (int a = 0; a < 16; a++) begin
            run4(a, res, lat);
            if (a == 0) check("m4_zero", res, 0);
            else        check("m4_product", gmul(a, res, 4, 'h13), 1);
        end
`endif

        for (int i = 0; i < 40; i++) begin
            d  = int'($urandom_range(0, 255));
            md = int'($urandom_range(0, 1));
            run8(d, md, res, lat);
            check("rand_result", res, ref8(d, md));
            check("rand_latency", lat, 8);
        end

        // Start during CALC must be ignored.
        @(negedge clk);
        en8 = 1'b1; din8 = 8'h53; md8 = 1'b0;
        @(posedge clk); #1;
        en8 = 1'b0;
        check("busy_after_accept", busy8, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        en8 = 1'b1; din8 = 8'hA7; md8 = 1'b1;
        @(negedge clk);
        en8 = 1'b0;
        pulses = 0; res = -1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done8) begin pulses++; res = int'(dout8); end
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_result", res, ref8('h53, 0));

        // Enable held high: accepts every M+1 cycles, each in the done cycle.
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            en8 = 1'b1; md8 = 1'b0;
            din8 = 8'($urandom_range(0, 255));
            if (c % 9 == 0) exp_q.push_back(int'(din8));
            @(posedge clk); #1;
            check("hold_done", done8, (c % 9 == 8) ? 1 : 0);
            if (c % 9 == 8 && exp_q.size() > 0)
                check("hold_result", dout8, ref8(exp_q.pop_front(), 0));
        end
        @(negedge clk);
        en8 = 1'b0;
        repeat (12) @(posedge clk);

        // Reset in CALC cycle 3 aborts with no done pulse.
        run8('h53, 0, res, lat);
        @(negedge clk);
        en8 = 1'b1; din8 = 8'h9E; md8 = 1'b0;
        @(posedge clk); #1;
        en8 = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_data_out", dout8, 0);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        check("abort_no_done", pulses, 0);
        d = int'($urandom_range(1, 255));
        run8(d, 0, res, lat);
        check("after_abort_result", res, ref8(d, 0));
        check("after_abort_latency", lat, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
